// File: rtl/register_demuxer_if.sv
// Bus bundle between the register stream front end and register_demuxer:
// the incoming {index, value} stream, the commit strobe, readback and status.
interface register_demuxer_if #(
    parameter int INDEX_WIDTH = 4,
    parameter int VALUE_WIDTH = 23
);
    localparam int SLOTS = 2 ** INDEX_WIDTH;

    logic [INDEX_WIDTH-1:0]       register_index;
    logic [VALUE_WIDTH-1:0]       register_value;
    logic                         frame_start;
    logic [INDEX_WIDTH-1:0]       read_index;
    logic [VALUE_WIDTH-1:0]       read_value;
    logic [SLOTS*VALUE_WIDTH-1:0] registers_flat;
    logic [SLOTS-1:0]             dirty_mask;
    logic                         pending;
    logic                         write_strobe;
    logic [INDEX_WIDTH-1:0]       write_index;

    modport master (
        output register_index, register_value, frame_start, read_index,
        input  read_value, registers_flat, dirty_mask, pending, write_strobe, write_index
    );

    modport slave (
        input  register_index, register_value, frame_start, read_index,
        output read_value, registers_flat, dirty_mask, pending, write_strobe, write_index
    );
endinterface

// File: rtl/register_demuxer.sv
// Decodes the {index, value} register stream into shadow registers and commits
// dirty shadows to the active bank on frame_start, so consumers see whole frames.
module register_demuxer #(
    parameter int INDEX_WIDTH = 4,
    parameter int VALUE_WIDTH = 23
) (
    input  logic               clk,
    input  logic               reset,
    register_demuxer_if.slave  bus
);
    localparam int SLOTS = 2 ** INDEX_WIDTH;

    logic                   write_en;
    logic [VALUE_WIDTH-1:0] active_arr [SLOTS];
    logic [VALUE_WIDTH-1:0] read_value_q;
    logic                   write_strobe_q;
    logic [INDEX_WIDTH-1:0] write_index_q;

    // Index 0 is the idle marker, so it never matches a slot and slot 0 stays zero.
    assign write_en = (bus.register_index != '0);

    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slot
            logic [VALUE_WIDTH-1:0] shadow_q, shadow_d;
            logic [VALUE_WIDTH-1:0] active_q, active_d;
            logic                   dirty_q, dirty_d;
            logic                   hit;

            assign hit = write_en && (bus.register_index == INDEX_WIDTH'(gi));

            // Applying the write before the commit lets a same-cycle write bypass
            // straight into the active bank.
            always_comb begin
                shadow_d = shadow_q;
                active_d = active_q;
                dirty_d  = dirty_q;
                if (hit) begin
                    shadow_d = bus.register_value;
                    dirty_d  = 1'b1;
                end
                if (bus.frame_start) begin
                    if (dirty_d) begin
                        active_d = shadow_d;
                    end
                    dirty_d = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    shadow_q <= '0;
                    active_q <= '0;
                    dirty_q  <= 1'b0;
                end else begin
                    shadow_q <= shadow_d;
                    active_q <= active_d;
                    dirty_q  <= dirty_d;
                end
            end

            assign active_arr[gi]                                 = active_q;
            assign bus.registers_flat[gi*VALUE_WIDTH +: VALUE_WIDTH] = active_q;
            assign bus.dirty_mask[gi]                             = dirty_q;
        end
    endgenerate

    assign bus.pending = |bus.dirty_mask;

    // Readback samples the active bank as it was before this edge's commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_value_q   <= '0;
            write_strobe_q <= 1'b0;
            write_index_q  <= '0;
        end else begin
            read_value_q   <= active_arr[bus.read_index];
            write_strobe_q <= write_en;
            if (write_en) begin
                write_index_q <= bus.register_index;
            end
        end
    end

    assign bus.read_value   = read_value_q;
    assign bus.write_strobe = write_strobe_q;
    assign bus.write_index  = write_index_q;
endmodule

// File: tb/tb_register_demuxer.sv
// Bench for register_demuxer: directed vector table followed by random traffic
// checked against a slot-array reference model.
module tb_register_demuxer;
    localparam int IW = 4;
    localparam int VW = 23;
    localparam int SLOTS = 16;
    localparam int FW = SLOTS * VW;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    register_demuxer_if #(.INDEX_WIDTH(IW), .VALUE_WIDTH(VW)) bus ();

    register_demuxer #(.INDEX_WIDTH(IW), .VALUE_WIDTH(VW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [IW-1:0] idx;
        logic [VW-1:0] val;
        logic          fs;
        logic [IW-1:0] ridx;
        logic [15:0]   e_dirty;
        logic          e_strobe;
        logic [IW-1:0] e_widx;
        logic [IW-1:0] cslot;
        logic [VW-1:0] e_cval;
        logic [VW-1:0] e_rval;
    } vec_t;

    vec_t vq[$];

    logic [VW-1:0] m_shadow [SLOTS];
    logic [VW-1:0] m_active [SLOTS];
    logic          m_dirty  [SLOTS];

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [IW-1:0] idx, input logic [VW-1:0] val,
                       input logic fs, input logic [IW-1:0] ridx, input logic [15:0] ed,
                       input logic es, input logic [IW-1:0] ew, input logic [IW-1:0] cs,
                       input logic [VW-1:0] ecv, input logic [VW-1:0] erv);
        vec_t v;
        v.rst = rst; v.idx = idx; v.val = val; v.fs = fs; v.ridx = ridx;
        v.e_dirty = ed; v.e_strobe = es; v.e_widx = ew; v.cslot = cs;
        v.e_cval = ecv; v.e_rval = erv;
        vq.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic [IW-1:0] idx, input logic [VW-1:0] val,
                         input logic fs, input logic [IW-1:0] ridx);
        reset              = rst;
        bus.register_index = idx;
        bus.register_value = val;
        bus.frame_start    = fs;
        bus.read_index     = ridx;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [VW-1:0] slot_of(input int s);
        return bus.registers_flat[s*VW +: VW];
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        bus.register_index = '0;
        bus.register_value = '0;
        bus.frame_start    = 1'b0;
        bus.read_index     = '0;

        // 1: reset sweep of the readback port
        for (int i = 0; i < SLOTS; i++)
            add(0, 4'd0, 23'h0, 0, 4'(i), 16'h0000, 0, 4'd0, 4'(i), 23'h0, 23'h0);
        // 2: single write, then commit
        add(0, 4'd3, 23'h12345, 0, 4'd3, 16'h0008, 1, 4'd3, 4'd3, 23'h0, 23'h0);
        add(0, 4'd0, 23'h0,     0, 4'd3, 16'h0008, 0, 4'd0, 4'd3, 23'h0, 23'h0);
        add(0, 4'd0, 23'h0,     1, 4'd3, 16'h0000, 0, 4'd0, 4'd3, 23'h12345, 23'h0);
        add(0, 4'd0, 23'h0,     0, 4'd3, 16'h0000, 0, 4'd0, 4'd3, 23'h12345, 23'h12345);
        // 3: idle index with a loud value, then an empty commit
        for (int i = 0; i < 5; i++)
            add(0, 4'd0, 23'h7FFFFF, 0, 4'd0, 16'h0000, 0, 4'd0, 4'd0, 23'h0, 23'h0);
        add(0, 4'd0, 23'h7FFFFF, 1, 4'd0, 16'h0000, 0, 4'd0, 4'd0, 23'h0, 23'h0);
        // 4: alternating overwrites before commit
        add(0, 4'd2, 23'h111, 0, 4'd2, 16'h0004, 1, 4'd2, 4'd2, 23'h0, 23'h0);
        add(0, 4'd5, 23'h222, 0, 4'd2, 16'h0024, 1, 4'd5, 4'd5, 23'h0, 23'h0);
        add(0, 4'd2, 23'h333, 0, 4'd2, 16'h0024, 1, 4'd2, 4'd2, 23'h0, 23'h0);
        add(0, 4'd5, 23'h444, 0, 4'd5, 16'h0024, 1, 4'd5, 4'd5, 23'h0, 23'h0);
        add(0, 4'd0, 23'h0,   1, 4'd2, 16'h0000, 0, 4'd0, 4'd2, 23'h333, 23'h0);
        add(0, 4'd0, 23'h0,   0, 4'd2, 16'h0000, 0, 4'd0, 4'd5, 23'h444, 23'h333);
        // 5: write bypassing into a same-cycle commit
        add(0, 4'd7, 23'h0ABCDE, 1, 4'd0, 16'h0000, 1, 4'd7, 4'd7, 23'h0ABCDE, 23'h0);
        add(0, 4'd0, 23'h0,      0, 4'd7, 16'h0000, 0, 4'd0, 4'd7, 23'h0ABCDE, 23'h0ABCDE);
        // 6: reset discards a pending write; the following commit has nothing to do
        add(0, 4'd9, 23'h55, 0, 4'd9, 16'h0200, 1, 4'd9, 4'd9, 23'h0, 23'h0);
        add(1, 4'd9, 23'h77, 0, 4'd9, 16'h0000, 0, 4'd0, 4'd9, 23'h0, 23'h0);
        add(0, 4'd0, 23'h0,  1, 4'd9, 16'h0000, 0, 4'd0, 4'd9, 23'h0, 23'h0);
        add(0, 4'd0, 23'h0,  0, 4'd9, 16'h0000, 0, 4'd0, 4'd9, 23'h0, 23'h0);

        repeat (3) @(posedge clk);
        @(negedge clk);

        foreach (vq[k]) begin
            drive(vq[k].rst, vq[k].idx, vq[k].val, vq[k].fs, vq[k].ridx);
            $display("vec %0d: rst=%0d idx=%0d val=%0h fs=%0d ridx=%0d -> dirty=%04h strobe=%0d rval=%0h",
                     k, vq[k].rst, vq[k].idx, vq[k].val, vq[k].fs, vq[k].ridx,
                     bus.dirty_mask, bus.write_strobe, bus.read_value);
            chk($sformatf("vec%0d dirty_mask", k), FW'(bus.dirty_mask), FW'(vq[k].e_dirty));
            chk($sformatf("vec%0d pending", k), FW'(bus.pending), FW'(|vq[k].e_dirty));
            chk($sformatf("vec%0d write_strobe", k), FW'(bus.write_strobe), FW'(vq[k].e_strobe));
            if (vq[k].e_strobe)
                chk($sformatf("vec%0d write_index", k), FW'(bus.write_index), FW'(vq[k].e_widx));
            chk($sformatf("vec%0d slot%0d", k, vq[k].cslot), FW'(slot_of(int'(vq[k].cslot))), FW'(vq[k].e_cval));
            chk($sformatf("vec%0d read_value", k), FW'(bus.read_value), FW'(vq[k].e_rval));
        end

        // Random traffic; the first step is a reset so the model starts aligned.
        for (int n = 0; n < 400; n++) begin
            logic          r, fs, e_strobe;
            logic [IW-1:0] idx, ridx, e_widx;
            logic [VW-1:0] val, e_rval;
            logic [FW-1:0] e_flat;
            logic [15:0]   e_dirty;
            r    = (n == 0) || ($urandom_range(0, 99) < 2);
            idx  = ($urandom_range(0, 99) < 30) ? 4'd0 : 4'($urandom_range(1, 15));
            val  = 23'($urandom);
            fs   = ($urandom_range(0, 99) < 15);
            ridx = 4'($urandom_range(0, 15));
            e_widx = '0;
            if (r) begin
                for (int i = 0; i < SLOTS; i++) begin
                    m_shadow[i] = '0; m_active[i] = '0; m_dirty[i] = 1'b0;
                end
                e_rval = '0; e_strobe = 1'b0;
            end else begin
                e_rval   = m_active[ridx];
                e_strobe = (idx != 0);
                if (idx != 0) begin
                    e_widx = idx;
                    m_shadow[idx] = val;
                    m_dirty[idx]  = 1'b1;
                end
                if (fs) begin
                    for (int i = 0; i < SLOTS; i++) begin
                        if (m_dirty[i]) m_active[i] = m_shadow[i];
                        m_dirty[i] = 1'b0;
                    end
                end
            end
            for (int i = 0; i < SLOTS; i++) begin
                e_flat[i*VW +: VW] = m_active[i];
                e_dirty[i] = m_dirty[i];
            end
            drive(r, idx, val, fs, ridx);
            $display("rnd %0d: rst=%0d idx=%0d val=%0h fs=%0d ridx=%0d -> dirty=%04h rval=%0h",
                     n, r, idx, val, fs, ridx, bus.dirty_mask, bus.read_value);
            chk($sformatf("rnd%0d dirty_mask", n), FW'(bus.dirty_mask), FW'(e_dirty));
            chk($sformatf("rnd%0d pending", n), FW'(bus.pending), FW'(|e_dirty));
            chk($sformatf("rnd%0d write_strobe", n), FW'(bus.write_strobe), FW'(e_strobe));
            if (e_strobe)
                chk($sformatf("rnd%0d write_index", n), FW'(bus.write_index), FW'(e_widx));
            chk($sformatf("rnd%0d read_value", n), FW'(bus.read_value), FW'(e_rval));
            chk($sformatf("rnd%0d registers_flat", n), bus.registers_flat, e_flat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
